// File: rtl/axi4_lite_read_requester.sv
// Single-outstanding AXI4-Lite read master: turns a local req/rsp handshake into one
// AR/R exchange, rejects misaligned addresses locally and bounds the wait for R.
module axi4_lite_read_requester #(
  parameter int ADDRESS_SIZE   = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_clk_i,
  input  logic [ADDRESS_SIZE-1:0] req_address_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output logic [DATA_SIZE-1:0]    rsp_data_o,
  output logic [1:0]              rsp_response_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ADDRESS_SIZE-1:0] read_address_o,
  output logic                    read_address_valid_o,
  input  logic                    read_address_ready_i,
  input  logic [DATA_SIZE-1:0]    read_data_i,
  input  logic [1:0]              read_data_response_i,
  input  logic                    read_data_valid_i,
  output logic                    read_data_ready_o,
  output logic [1:0]              debug_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid output, once raised, holds its payload stable until that edge.

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam int CW        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LIMIT_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(LIMIT_INT);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  state_t                  state_q, state_d;
  logic                    orphan_q, orphan_d;
  logic [CW-1:0]           counter_q, counter_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic [1:0]              resp_q, resp_d;
  logic                    timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (counter_q == CNT_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      state_q   <= IDLE;
      orphan_q  <= 1'b0;
      counter_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      orphan_q  <= orphan_d;
      counter_q <= counter_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    orphan_d  = orphan_q;
    counter_d = counter_q;
    addr_d    = addr_q;
    data_d    = data_q;
    resp_d    = resp_q;

    // A late R beat from a timed-out read is swallowed; it never reaches rsp_*.
    if (orphan_q && read_data_valid_i) orphan_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !orphan_q) begin
          addr_d = req_address_i;
          if (req_address_i[1:0] != 2'b00) begin
            data_d  = '0;
            resp_d  = RESP_SLVERR;
            state_d = RESP;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (read_address_ready_i) begin
          counter_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (read_data_valid_i) begin
          data_d  = read_data_i;
          resp_d  = read_data_response_i;
          state_d = RESP;
        end else if (timeout_hit) begin
          data_d   = '0;
          resp_d   = RESP_TIMEOUT;
          orphan_d = 1'b1;
          state_d  = RESP;
        end else if (counter_q != CNT_MAX) begin
          counter_d = counter_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o          = (state_q == IDLE) && !orphan_q;
  assign read_address_valid_o = (state_q == ADDR);
  assign read_address_o       = addr_q;
  assign read_data_ready_o    = (state_q == DATA) || orphan_q;
  assign rsp_valid_o          = (state_q == RESP);
  assign rsp_data_o           = data_q;
  assign rsp_response_o       = resp_q;
  assign debug_state          = state_q;

endmodule

// File: tb/tb_axi4_lite_read_requester.sv
// Bench for axi4_lite_read_requester: directed scenarios plus randomized reads, with the
// expected response of each read derived from its address and the slave's R timing.
module tb_axi4_lite_read_requester;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_address;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  axi4_lite_read_requester #(
    .ADDRESS_SIZE(32), .DATA_SIZE(32), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_clk_i(rst),
    .req_address_i(req_address), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rsp_data_o(rsp_data), .rsp_response_o(rsp_resp), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .read_address_o(araddr), .read_address_valid_o(arvalid),
    .read_address_ready_i(arready),
    .read_data_i(r_data), .read_data_response_i(r_resp), .read_data_valid_i(r_valid),
    .read_data_ready_o(r_ready),
    .debug_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_araddr"}, araddr, 0);
    check({tag, "_rready"}, r_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_resp"}, rsp_resp, 0);
  endtask

  // One complete read. The bench plays the AXI slave: ARREADY after ar_delay cycles,
  // RVALID on DATA cycle r_delay (r_delay >= TIMEOUT means R only arrives late).
  task automatic do_read(input logic [31:0] addr, input int ar_delay, input int r_delay,
                         input logic [31:0] rdata, input logic [1:0] rresp,
                         input int rsp_delay);
    logic [33:0] exp;
    bit          late;
    late = 1'b0;
    check("idle_req_ready", req_ready, 1);
    check("idle_rready", r_ready, 0);
    req_valid   = 1'b1;
    req_address = addr;
    step();
    req_valid   = 1'b0;
    req_address = $urandom;
    if (addr[1:0] != 2'b00) begin
      exp = {32'h0, 2'b10};
      check("misaligned_arvalid", arvalid, 0);
    end else begin
      for (int i = 0; i < ar_delay; i++) begin
        check("ar_wait_arvalid", arvalid, 1);
        check("ar_wait_araddr", araddr, addr);
        check("ar_wait_rsp_valid", rsp_valid, 0);
        step();
      end
      check("ar_arvalid", arvalid, 1);
      check("ar_araddr", araddr, addr);
      arready = 1'b1;
      step();
      arready = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
        check("data_rready", r_ready, 1);
        check("data_arvalid", arvalid, 0);
        check("data_rsp_valid", rsp_valid, 0);
        if (i == r_delay) begin
          r_valid = 1'b1;
          r_data  = rdata;
          r_resp  = rresp;
        end
        step();
        r_valid = 1'b0;
        r_data  = $urandom;
        if (i == r_delay) break;
      end
      if (r_delay < TIMEOUT) exp = {rdata, rresp};
      else begin
        exp  = {32'h0, 2'b11};
        late = 1'b1;
      end
    end
    exp_q.push_back(exp);

    for (int i = 0; i < rsp_delay; i++) begin
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_payload", {rsp_data, rsp_resp}, exp_q[0]);
      check("rsp_hold_arvalid", arvalid, 0);
      step();
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_payload", {rsp_data, rsp_resp}, exp_q.pop_front());
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);

    if (late) begin
      for (int i = 0; i < $urandom_range(1, 3); i++) begin
        check("orphan_req_ready", req_ready, 0);
        check("orphan_rready", r_ready, 1);
        step();
      end
      r_valid = 1'b1;
      r_data  = 32'h1234;
      r_resp  = 2'b00;
      step();
      r_valid = 1'b0;
      check("drained_req_ready", req_ready, 1);
      check("drained_rready", r_ready, 0);
      check("drained_rsp_valid", rsp_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_address = '0; rsp_ready = 1'b0;
    arready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    do_read(32'h0000_0008, 0, 0, 32'hDEAD_BEEF, 2'b00, 0);   // zero-wait, rsp cycle 3
    do_read(32'h0000_0100, 5, 1, 32'hCAFE_0001, 2'b00, 0);   // ARREADY held off
    do_read(32'h0000_0006, 0, 0, 32'h0, 2'b00, 0);           // misaligned
    do_read(32'h0000_0040, 0, TIMEOUT, 32'h0, 2'b00, 1);     // timeout then late R
    do_read(32'h0000_0044, 1, TIMEOUT - 1, 32'h5555_AAAA, 2'b10, 0); // R on timeout cycle
    do_read(32'h0000_0048, 0, 0, 32'h0BAD_F00D, 2'b00, 3);   // consumer stalls

    // reset while waiting in DATA abandons the read
    req_valid = 1'b1; req_address = 32'h0000_0080;
    step();
    req_valid = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("pre_reset_rready", r_ready, 1);
    rst = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    step();

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      else a[1:0] = 2'($urandom_range(1, 3));
      do_read(a, $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 1), $urandom,
              ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
